// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, serialiser state encoding and a parity helper
// shared by the buffered UART transmitter.
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty come from an extra pointer wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with internal baud divider,
// configurable parity and stop bits; frames leave back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    state_t                 state, state_nxt;
    logic                   full, empty, pop, serial_nxt, done_nxt;
    logic [DATA_BITS-1:0]   fifo_dout, shift;
    logic [DIV_W-1:0]       cnt, div_q, div_eff;
    logic [3:0]             bit_idx;
    logic                   par_en_q, par_q, stop2_q;
    logic                   bit_end, last_data, last_stop;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && !full),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign tx_ready  = !full;
    assign busy      = state != S_IDLE;
    assign div_eff   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign bit_end   = cnt == div_q - DIV_W'(1);
    assign last_data = bit_idx == 4'(DATA_BITS - 1);
    assign last_stop = !stop2_q || bit_idx == 4'd1;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        serial_nxt = tx_serial;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                serial_nxt = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    state_nxt  = S_START;
                    serial_nxt = 1'b0;
                end
            end
            S_START: if (bit_end) begin
                state_nxt  = S_DATA;
                serial_nxt = shift[0];
            end
            S_DATA: if (bit_end) begin
                state_nxt  = last_data ? (par_en_q ? S_PARITY : S_STOP) : S_DATA;
                serial_nxt = last_data ? (par_en_q ? par_q : 1'b1) : shift[1];
            end
            S_PARITY: if (bit_end) begin
                state_nxt  = S_STOP;
                serial_nxt = 1'b1;
            end
            S_STOP: if (bit_end && last_stop) begin
                done_nxt   = 1'b1;
                pop        = !empty;
                state_nxt  = empty ? S_IDLE : S_START;
                serial_nxt = empty;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_serial <= serial_nxt;
            tx_done   <= done_nxt;
        end
    end

    // Frame settings are captured at pop so mid-frame config changes wait for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            div_q    <= '0;
            shift    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            cnt     <= (state == S_IDLE || bit_end) ? '0 : cnt + DIV_W'(1);
            bit_idx <= (state_nxt != state) ? '0 : bit_idx + 4'(bit_end);
            if (pop) begin
                div_q    <= div_eff;
                shift    <= fifo_dout;
                par_en_q <= !(cfg_parity == PAR_NONE || cfg_parity == 2'b11);
                par_q    <= calc_parity(9'(fifo_dout), cfg_parity);
                stop2_q  <= cfg_stop2;
            end else if (state == S_DATA && bit_end) begin
                shift <= shift >> 1;
            end
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter. Successor to the fixed 8N1 transmitter that relies on an external baud generator.
- Baud divider is internal and runtime-programmable.
- Data width, parity and stop-bit count are configurable.
- A FIFO decouples the valid/ready producer from the serial line, so frames go out back-to-back with no idle gap.
- Sits between user logic (or ui_in) and a uo_out pin.

Parameters:
DATA_BITS, 8, payload bits per frame (legal 5..9)
FIFO_DEPTH, 4, FIFO entries (power of two, >=2)
DIV_W, 16, width of the baud divisor input

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_div  input  DIV_W  clocks per bit; values <2 treated as 2
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits
tx_valid  input  1  producer has data
tx_data  input  DATA_BITS  payload
tx_ready  output  1  FIFO can accept (= !full)
tx_serial  output  1  UART line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low), asynchronous, including mid-frame:
  - tx_serial=1, busy=0, tx_done=0, fifo_count=0, tx_ready=1.
  - FIFO contents discarded; FSM forced to IDLE.
- Handshake:
  - Write happens on a rising edge with tx_valid && tx_ready.
  - tx_ready depends only on full, so there is no same-cycle push-when-full even if a pop occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Pop rule: pop occurs on the edge the FSM enters START, either from IDLE with FIFO non-empty, or at the end of STOP with FIFO non-empty.
  - cfg_div, cfg_parity and cfg_stop2 are latched at pop; changes mid-frame have no effect.
- Latency: byte pushed into an empty FIFO while IDLE at edge k → tx_serial low from edge k+1.
- Bit timing:
  - Bit counter is cleared on entry to START; each bit lasts exactly div_eff = max(cfg_div,2) clocks.
  - tx_serial is registered and changes on the same edge as the state.
- Bit sequence:
  - START: 0.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY (only if enabled): even = XOR of data bits; odd = its inverse.
  - STOP: 1 for one or two bit periods.
- Frame length: (1 + DATA_BITS + P + S) × div_eff clocks, where P = 1 if parity enabled else 0, and S = 2 if cfg_stop2 else 1.
- End of STOP:
  - tx_done pulses for the one cycle following the final stop-bit clock.
  - If the FIFO is non-empty → START on the same edge (no idle gap); else → IDLE.
- busy: high in START/DATA/PARITY/STOP.
- fifo_count: updates on the edge after push/pop; simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty determined by an extra pointer bit.

Decomposition:
- Package uart_pkg:
  - parity constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10.
  - FSM state encoding.
  - helper function for parity over DATA_BITS.
- Sub-module sync_fifo (WIDTH, DEPTH), with push/pop/full/empty/count ports.
- Top instantiates sync_fifo plus the serialiser FSM and baud counter.

Test Plan:
1. 8N1, cfg_div=4, push 0x41 while idle → tx_serial 0,1,0,0,0,0,0,1,0,1, each 4 clocks, 40 clocks total; falling edge one cycle after acceptance; tx_done pulses once; busy falls with it.
2. cfg_parity=01 then 10, cfg_div=4, push 0x41 → parity bit 0 (even) and 1 (odd); frame 44 clocks; with cfg_stop2=1 stop high 8 clocks, frame 48.
3. Push 0x11, wait for busy, push 0x22,0x33,0x44,0x55 → fifo_count=4, tx_ready=0; extra push 0x66 ignored; all five frames sent back-to-back in order with no idle clocks between stop and next start.
4. cfg_div=0 and cfg_div=1 → each bit lasts 2 clocks; cfg_div changed mid-frame → current frame unaffected, next frame uses the new value.
5. rst_n low mid-DATA with 3 bytes queued → tx_serial=1 immediately; busy=0, fifo_count=0, tx_ready=1; after release no frame is sent until a new push.
6. DATA_BITS=5 build, push 5'h15 with even parity → bits 1,0,1,0,1, parity 1, frame 8 × div_eff clocks.
